// File: rtl/cdc_4phase_pkg.sv
// Shared types and the round-robin pick helper for the 4-phase
// destination arbiter. No ports; imported by the arbiter files.
package cdc_4phase_pkg;

    localparam int MAX_CH = 32;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_ACKED = 1'b1
    } ch_state_e;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // First set bit of pending, searching upward from last+1 and
    // wrapping at num_ch. Passing last = num_ch-1 gives lowest-index-wins.
    function automatic pick_t rr_pick(
        input logic [MAX_CH-1:0] pending,
        input int unsigned       last,
        input int unsigned       num_ch
    );
        pick_t      r;
        logic [5:0] c;
        r = '0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            c = 6'(last + i);
            if (c >= 6'(num_ch)) begin
                c = c - 6'(num_ch);
            end
            if (i <= num_ch && !r.found && pending[c[4:0]]) begin
                r.found = 1'b1;
                r.idx   = c[4:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit synchroniser: SYNC_STAGES flops, synchronous active-high reset.
// Ports: clk_i, rst_i, d_i (async in), q_o (synchronised out).
module cdc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] ff_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_4phase_dst_arb.sv
// Multi-channel 4-phase handshake destination with round-robin grant
// into a one-entry valid/ready output stage tagged by channel.
// Ports: clk_i, rst_i (sync, active-high), async_req_i, async_ack_o,
//   async_data_i (ch k at [k*DATA_W +: DATA_W]), data_o, ch_o,
//   valid_o, ready_i.
// Macro CDC_4PHASE_ARB_FIXED_PRIO_EN: lowest pending index always wins.
module cdc_4phase_dst_arb
    import cdc_4phase_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  DATA_W      = 32,
    parameter int  SYNC_STAGES = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        async_req_i,
    output logic [NUM_CH-1:0]        async_ack_o,
    input  logic [NUM_CH*DATA_W-1:0] async_data_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [CH_W-1:0]          ch_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] ack_q;
    ch_state_e         state_q [NUM_CH];

    logic [MAX_CH-1:0] pend_w;
    pick_t             pick;
    int unsigned       gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic              free;
    logic              grant;

`ifndef CDC_4PHASE_ARB_FIXED_PRIO_EN
    logic [CH_W-1:0]   last_q;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_sync
        cdc_sync_bit #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (async_req_i[k]),
            .q_o   (req_s[k])
        );
        // An acked channel is never pending: one delivery per handshake.
        assign pending[k] = (state_q[k] == CH_IDLE) && req_s[k];
    end

    assign free = !valid_o || ready_i;

    always_comb begin
        pend_w = '0;
        pend_w[NUM_CH-1:0] = pending;
`ifdef CDC_4PHASE_ARB_FIXED_PRIO_EN
        pick = rr_pick(pend_w, NUM_CH - 1, NUM_CH);
`else
        pick = rr_pick(pend_w, 32'(last_q), NUM_CH);
`endif
        gnt_idx  = 32'(pick.idx);
        gnt_data = async_data_i[gnt_idx*DATA_W +: DATA_W];
        grant    = free && pick.found;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= CH_IDLE;
            end
            ack_q   <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
            ch_o    <= '0;
`ifndef CDC_4PHASE_ARB_FIXED_PRIO_EN
            last_q  <= CH_W'(NUM_CH - 1);
`endif
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (state_q[k] == CH_ACKED && !req_s[k]) begin
                    state_q[k] <= CH_IDLE;
                    ack_q[k]   <= 1'b0;
                end
            end
            if (grant) begin
                data_o           <= gnt_data;
                ch_o             <= CH_W'(pick.idx);
                valid_o          <= 1'b1;
                ack_q[gnt_idx]   <= 1'b1;
                state_q[gnt_idx] <= CH_ACKED;
`ifndef CDC_4PHASE_ARB_FIXED_PRIO_EN
                last_q           <= CH_W'(pick.idx);
`endif
            end else if (free) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign async_ack_o = ack_q;

endmodule
